rv_run_ctrl: RTL and testbench

- Synthesizable run controller for the RV32IM core.
- Sequences per-domain core resets with a programmable hold time and staggered release, so the posedge and negedge domains (clk/neg_clk) leave reset in a fixed order.
- Counts run cycles and detects end of program: the PC self-loops (`j .`) for STALL_CYC cycles.
- Enforces a cycle-budget timeout, then freezes the core and reports status. Usable on FPGA and in simulation harnesses.

---
 rtl/rv_soc_pkg.sv | 15 +
 rtl/rv_pc_stall_det.sv | 48 ++++
 rtl/rv_run_ctrl.sv | 145 ++++++++++++++
 tb/tb_rv_run_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv_soc_pkg.sv
// Shared types and default widths for the RV32IM SoC run-control slice.
package rv_soc_pkg;

    localparam int PC_W_DEF  = 10;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [2:0] {
        ST_HOLD    = 3'd0,
        ST_RELEASE = 3'd1,
        ST_RUN     = 3'd2,
        ST_DONE    = 3'd3,
        ST_TOUT    = 3'd4
    } run_state_t;

endpackage

// File: rtl/rv_pc_stall_det.sv
// PC self-loop detector: flags the sample that completes STALL_CYC consecutive
// equal PC samples (the first sample after clear counts as one of them).
module rv_pc_stall_det
    import rv_soc_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int STALL_CYC = 8
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            en_i,
    input  logic            clr_i,
    input  logic [PC_W-1:0] pc_i,
    output logic            stall_hit_o
);

    localparam int SW = (STALL_CYC > 2) ? $clog2(STALL_CYC) : 1;

    logic [PC_W-1:0] prev_pc_q;
    logic            pc_valid_q;
    logic [SW-1:0]   stall_cnt_q;
    logic            match_s;

    assign match_s     = pc_valid_q && (pc_i == prev_pc_q);
    assign stall_hit_o = match_s && (stall_cnt_q == SW'(STALL_CYC - 2));

    // Track previous PC and length of the current run of equal samples.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            prev_pc_q   <= '0;
            pc_valid_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else if (clr_i) begin
            prev_pc_q   <= '0;
            pc_valid_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else if (en_i) begin
            prev_pc_q   <= pc_i;
            pc_valid_q  <= 1'b1;
            stall_cnt_q <= match_s ? (stall_cnt_q + SW'(1)) : '0;
        end else begin
            prev_pc_q   <= prev_pc_q;
            pc_valid_q  <= pc_valid_q;
            stall_cnt_q <= stall_cnt_q;
        end
    end

endmodule

// File: rtl/rv_run_ctrl.sv
// Run controller: staggered per-domain reset release, run-cycle counting,
// end-of-program (PC self-loop) detection and cycle-budget timeout.
module rv_run_ctrl
    import rv_soc_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int NCH       = 2,
    parameter int HOLD_CYC  = 5,
    parameter int STAGGER   = 1,
    parameter int STALL_CYC = 8,
    parameter int TIMEOUT   = 100,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [PC_W-1:0]   pc_in,
    output logic [NCH-1:0]    core_rst_o,
    output logic              running,
    output logic              done,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [PC_W-1:0]   final_pc
);

    localparam int LAST_T = HOLD_CYC + (NCH - 1) * STAGGER;
    localparam int TW     = $clog2(LAST_T + 1) + 1;

    run_state_t       state_q;
    logic [TW-1:0]    t_q;
    logic [TW-1:0]    t_d;
    logic [NCH-1:0]   core_rst_q;
    logic             running_q;
    logic             done_q;
    logic             timeout_q;
    logic [CNT_W-1:0] cycle_cnt_q;
    logic [CNT_W-1:0] cnt_inc_s;
    logic [PC_W-1:0]  final_pc_q;
    logic [NCH-1:0]   rel_s;
    logic             tout_hit_s;
    logic             stall_hit_s;
    logic             stall_en_s;
    logic             stall_clr_s;
    logic             restart_s;

    assign t_d         = t_q + TW'(1);
    assign cnt_inc_s   = (&cycle_cnt_q) ? cycle_cnt_q : (cycle_cnt_q + CNT_W'(1));
    assign tout_hit_s  = (TIMEOUT != 0) && (cnt_inc_s == CNT_W'(TIMEOUT));
    assign restart_s   = start && ((state_q == ST_DONE) || (state_q == ST_TOUT));
    assign stall_en_s  = (state_q == ST_RUN);
    assign stall_clr_s = restart_s;

    // Channel i is released once the hold timer reaches its staggered slot.
    always_comb begin
        rel_s = '0;
        for (int i = 0; i < NCH; i++) begin
            rel_s[i] = (int'(t_d) >= (HOLD_CYC + i * STAGGER));
        end
    end

    rv_pc_stall_det #(
        .PC_W      (PC_W),
        .STALL_CYC (STALL_CYC)
    ) u_stall_det (
        .clk_i       (clk),
        .rst_n_i     (rst),
        .en_i        (stall_en_s),
        .clr_i       (stall_clr_s),
        .pc_i        (pc_in),
        .stall_hit_o (stall_hit_s)
    );

    // Run-control FSM with all outputs held in registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_HOLD;
            t_q         <= '0;
            core_rst_q  <= '1;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            cycle_cnt_q <= '0;
            final_pc_q  <= '0;
        end else begin
            case (state_q)
                ST_HOLD, ST_RELEASE: begin
                    t_q        <= t_d;
                    core_rst_q <= ~rel_s;
                    if (t_d == TW'(LAST_T)) begin
                        state_q   <= ST_RUN;
                        running_q <= 1'b1;
                    end else if (rel_s[0]) begin
                        state_q <= ST_RELEASE;
                    end else begin
                        state_q <= ST_HOLD;
                    end
                end
                ST_RUN: begin
                    cycle_cnt_q <= cnt_inc_s;
                    // A completed stall takes priority over the budget expiring.
                    if (stall_hit_s) begin
                        state_q    <= ST_DONE;
                        done_q     <= 1'b1;
                        running_q  <= 1'b0;
                        core_rst_q <= '1;
                        final_pc_q <= pc_in;
                    end else if (tout_hit_s) begin
                        state_q    <= ST_TOUT;
                        timeout_q  <= 1'b1;
                        running_q  <= 1'b0;
                        core_rst_q <= '1;
                        final_pc_q <= pc_in;
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_DONE, ST_TOUT: begin
                    if (start) begin
                        state_q     <= ST_HOLD;
                        t_q         <= '0;
                        cycle_cnt_q <= '0;
                        done_q      <= 1'b0;
                        timeout_q   <= 1'b0;
                    end else begin
                        state_q <= state_q;
                    end
                end
                default: begin
                    state_q    <= ST_HOLD;
                    t_q        <= '0;
                    core_rst_q <= '1;
                    running_q  <= 1'b0;
                end
            endcase
        end
    end

    assign core_rst_o = core_rst_q;
    assign running    = running_q;
    assign done       = done_q;
    assign timeout    = timeout_q;
    assign cycle_cnt  = cycle_cnt_q;
    assign final_pc   = final_pc_q;

endmodule

// File: tb/tb_rv_run_ctrl.sv
// Directed, table-driven bench for rv_run_ctrl (default instance plus a
// four-channel, zero-stagger instance).
module tb_rv_run_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [9:0]  pc_in;
    logic [1:0]  core_rst_o;
    logic        running;
    logic        done;
    logic        timeout;
    logic [15:0] cycle_cnt;
    logic [9:0]  final_pc;

    logic        rst4;
    logic        start4;
    logic [9:0]  pc4;
    logic [3:0]  core_rst4;
    logic        running4;
    logic        done4;
    logic        timeout4;
    logic [15:0] cycle_cnt4;
    logic [9:0]  final_pc4;

    int checks;
    int errors;

    typedef struct {
        logic        start;
        logic [9:0]  pc;
        logic [1:0]  exp_rst;
        logic        exp_run;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[8];

    rv_run_ctrl u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pc_in      (pc_in),
        .core_rst_o (core_rst_o),
        .running    (running),
        .done       (done),
        .timeout    (timeout),
        .cycle_cnt  (cycle_cnt),
        .final_pc   (final_pc)
    );

    rv_run_ctrl #(
        .NCH      (4),
        .HOLD_CYC (3),
        .STAGGER  (0)
    ) u_dut4 (
        .clk        (clk),
        .rst        (rst4),
        .start      (start4),
        .pc_in      (pc4),
        .core_rst_o (core_rst4),
        .running    (running4),
        .done       (done4),
        .timeout    (timeout4),
        .cycle_cnt  (cycle_cnt4),
        .final_pc   (final_pc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Edges 1..6 after reset release or restart; optional start pulse on edge 1.
    task automatic release_seq(input string tag, input logic pulse);
        for (int e = 1; e <= 6; e++) begin
            start = (e == 1) ? pulse : 1'b0;
            tick();
            start = 1'b0;
            chk({tag, "_core_rst"}, 32'(core_rst_o),
                32'((e < 5) ? 2'b11 : ((e == 5) ? 2'b10 : 2'b00)));
            chk({tag, "_running"}, 32'(running), 32'(e == 6));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0; start = 1'b0; pc_in = 10'd0;
        rst4 = 1'b0; start4 = 1'b0; pc4 = 10'd0;

        for (int i = 0; i < 8; i++) begin
            vecs[i].start   = (i == 1);
            vecs[i].pc      = (i < 6) ? 10'd0 : 10'(4 * (i - 6));
            vecs[i].exp_rst = (i < 4) ? 2'b11 : ((i == 4) ? 2'b10 : 2'b00);
            vecs[i].exp_run = (i >= 5);
            vecs[i].exp_cnt = (i < 6) ? 16'd0 : 16'(i - 5);
        end

        // Reset state
        tick(); tick();
        chk("rst_core_rst", 32'(core_rst_o), 32'(2'b11));
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_cycle_cnt", 32'(cycle_cnt), 32'd0);
        chk("rst_final_pc", 32'(final_pc), 32'd0);
        chk("rst4_core_rst", 32'(core_rst4), 32'(4'hF));

        // Test 1: release timing (start pulse in HOLD is ignored)
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            start = vecs[i].start;
            pc_in = vecs[i].pc;
            tick();
            start = 1'b0;
            chk($sformatf("t1_core_rst_e%0d", i + 1), 32'(core_rst_o), 32'(vecs[i].exp_rst));
            chk($sformatf("t1_running_e%0d", i + 1), 32'(running), 32'(vecs[i].exp_run));
            chk($sformatf("t1_cnt_e%0d", i + 1), 32'(cycle_cnt), 32'(vecs[i].exp_cnt));
        end

        // Test 2: PC sticks at 0x3C from RUN cycle 20
        for (int n = 3; n <= 27; n++) begin
            pc_in = (n < 20) ? 10'(4 * (n - 1)) : 10'h3C;
            tick();
            if (n == 26) chk("t2_done_early", 32'(done), 32'd0);
        end
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_timeout", 32'(timeout), 32'd0);
        chk("t2_final_pc", 32'(final_pc), 32'h3C);
        chk("t2_core_rst", 32'(core_rst_o), 32'(2'b11));
        chk("t2_running", 32'(running), 32'd0);
        chk("t2_cnt", 32'(cycle_cnt), 32'd27);
        pc_in = 10'h111;
        tick(); tick(); tick();
        chk("t2_sticky_done", 32'(done), 32'd1);
        chk("t2_sticky_cnt", 32'(cycle_cnt), 32'd27);
        chk("t2_sticky_pc", 32'(final_pc), 32'h3C);

        // Test 3: restart, PC never repeats, timeout at 100
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t3_restart_done", 32'(done), 32'd0);
        chk("t3_restart_cnt", 32'(cycle_cnt), 32'd0);
        chk("t3_restart_core_rst", 32'(core_rst_o), 32'(2'b11));
        chk("t3_restart_final_pc", 32'(final_pc), 32'h3C);
        release_seq("t3", 1'b0);
        for (int n = 1; n <= 100; n++) begin
            pc_in = 10'(n);
            tick();
            if (n == 99) begin
                chk("t3_tout_early", 32'(timeout), 32'd0);
                chk("t3_running_99", 32'(running), 32'd1);
            end
        end
        chk("t3_timeout", 32'(timeout), 32'd1);
        chk("t3_done", 32'(done), 32'd0);
        chk("t3_cnt", 32'(cycle_cnt), 32'd100);
        chk("t3_final_pc", 32'(final_pc), 32'd100);
        chk("t3_core_rst", 32'(core_rst_o), 32'(2'b11));
        chk("t3_running", 32'(running), 32'd0);

        // Test 4: stall completes on the timeout edge -> DONE wins
        start = 1'b1;
        tick();
        start = 1'b0;
        release_seq("t4", 1'b0);
        for (int n = 1; n <= 100; n++) begin
            pc_in = (n < 93) ? 10'(n) : 10'h2A0;
            tick();
            if (n == 99) chk("t4_done_early", 32'(done), 32'd0);
        end
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_timeout", 32'(timeout), 32'd0);
        chk("t4_cnt", 32'(cycle_cnt), 32'd100);
        chk("t4_final_pc", 32'(final_pc), 32'h2A0);

        // Test 5: async reset mid-RUN, then start in HOLD is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        release_seq("t5a", 1'b0);
        for (int n = 1; n <= 10; n++) begin
            pc_in = 10'(n + 200);
            tick();
        end
        chk("t5_running_pre", 32'(running), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t5_async_core_rst", 32'(core_rst_o), 32'(2'b11));
        chk("t5_async_running", 32'(running), 32'd0);
        chk("t5_async_cnt", 32'(cycle_cnt), 32'd0);
        tick(); tick();
        @(negedge clk);
        rst = 1'b1;
        release_seq("t5b", 1'b1);

        // Test 6: four channels, no stagger, alternating PC never finishes
        rst4 = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            chk($sformatf("t6_core_rst_e%0d", e), 32'(core_rst4), 32'((e < 3) ? 4'hF : 4'h0));
            chk($sformatf("t6_running_e%0d", e), 32'(running4), 32'(e == 3));
        end
        for (int n = 1; n <= 30; n++) begin
            pc4 = n[0] ? 10'h010 : 10'h020;
            tick();
        end
        chk("t6_done", 32'(done4), 32'd0);
        chk("t6_running", 32'(running4), 32'd1);
        chk("t6_cnt", 32'(cycle_cnt4), 32'd30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
